binary_to_bcd_seq: RTL and testbench
====================================

// Module: binary_to_bcd_seq
//
// PURPOSE
//  Sequential double-dabble converter: binary operand -> packed BCD digits.
//  Upstream stage of the per-digit seven-segment decoders in the calculator datapath.
//  Each 4-bit slice of out_bcd drives one decoder directly, and every slice is always 0-9.
//  Valid/ready on both sides; one shift-and-add-3 iteration per cycle.
//
// PARAMETERS
//  IN_BITS  8  width of binary input; number of iteration cycles
//  DIGITS   3  BCD digits produced; must satisfy 10**DIGITS > 2**IN_BITS-1 (elab-time check)
//
// PORTS
//  clk      in   1          single clock, rising edge
//  rst_n    in   1          asynchronous, active-low reset
//  in_val   in   1          upstream operand valid
//  in_rdy   out  1          converter can accept an operand
//  in_bin   in   IN_BITS    unsigned binary operand
//  out_val  out  1          out_bcd holds a finished conversion
//  out_rdy  in   1          downstream accepts result
//  out_bcd  out  4*DIGITS   packed BCD, digit 0 = [3:0] (ones), digit k = [4k+3:4k]
//
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_rdy=1, out_val=0, out_bcd=0,
//   shift reg=0, counter=0. Reset mid-conversion aborts it; no partial result is ever flagged valid.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : in_rdy=1, out_val=0. On in_val&in_rdy, capture in_bin into shift reg,
//          clear BCD accumulator, cnt<=IN_BITS, go SHIFT.
//   SHIFT: in_rdy=0, out_val=0. Each edge:
//          (a) every BCD digit >=5 gets +3 (4-bit add, no carry out);
//          (b) {bcd,sh} <= {bcd,sh}<<1.
//          cnt decrements; when cnt==1 at the edge, go DONE.
//   DONE : out_val=1, in_rdy=0. out_bcd is stable and must not change while out_val=1.
//          On out_val&out_rdy, go IDLE.
//  Timing and throughput:
//   Latency: acceptance at edge 0 -> out_val high exactly IN_BITS cycles later (after edge IN_BITS).
//   Throughput: 1 operand per IN_BITS+2 cycles minimum.
//   No overlap: in_rdy is low outside IDLE, and in_val there is ignored.
//  Input, output and width rules:
//   in_bin is sampled only at the accept edge; later changes are ignored.
//   out_bcd is a direct register (no comb path from inputs) and holds the last result after handshake.
//   Upper digits are zero-filled (e.g. 7 -> 0x007).
//   Any digit reaching a value above 9 is a design error; the bench asserts against it.
//  Boundaries:
//   out_rdy low in DONE: hold indefinitely, no data loss.
//   out_rdy high on the first DONE cycle: single-cycle pulse of out_val.
//   IN_BITS=1: one SHIFT cycle.
//
// TESTING
//  1 in_bin=0, out_rdy=1 -> out_val after 8 cycles, out_bcd=12'h000, back to IDLE.
//  2 in_bin=255 -> out_bcd=12'h255; in_bin=100 -> 12'h100; in_bin=9 -> 12'h009.
//  3 out_rdy=0 for 6 cycles after result -> out_val held 1, out_bcd unchanged,
//    in_rdy=0; out_rdy=1 -> IDLE next edge.
//  4 rst_n pulsed low at SHIFT cycle 4 of 200 -> outputs zero immediately; next operand 42 -> 12'h042.
//  5 in_val held high with changing in_bin during SHIFT/DONE -> only first operand converted;
//    second accepted only after return to IDLE.
//  6 exhaustive 0..255 with random out_rdy -> each result matches reference divide/mod-10 model,
//    digits <=9, and latency is always 8.

Source files
------------

// File: rtl/binary_to_bcd_seq_if.sv
// ============================================================================
// Module      : binary_to_bcd_seq_if
// Description : Valid/ready handshake bundle for the binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface binary_to_bcd_seq_if #(
    parameter int IN_BITS = 8,
    parameter int DIGITS  = 3
);
    logic                  in_val;
    logic                  in_rdy;
    logic [IN_BITS-1:0]    in_bin;
    logic                  out_val;
    logic                  out_rdy;
    logic [4*DIGITS-1:0]   out_bcd;

    modport master (
        output in_val, in_bin, out_rdy,
        input  in_rdy, out_val, out_bcd
    );

    modport slave (
        input  in_val, in_bin, out_rdy,
        output in_rdy, out_val, out_bcd
    );
endinterface

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
// ============================================================================
// Module      : binary_to_bcd_seq
// Description : Sequential double-dabble binary-to-packed-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module binary_to_bcd_seq #(
    parameter int IN_BITS = 8,
    parameter int DIGITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    binary_to_bcd_seq_if.slave   bus
);

    localparam int                c_sr_w     = 4*DIGITS + IN_BITS;
    localparam int                c_cnt_w    = $clog2(IN_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(IN_BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam longint            c_max_in   = (64'sd1 <<< IN_BITS) - 64'sd1;
    localparam longint            c_bcd_span = 64'sd10 ** DIGITS;

    generate
        if (c_bcd_span <= c_max_in) begin : g_bad_params
            $error("binary_to_bcd_seq: DIGITS too small for IN_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic [IN_BITS-1:0]     sh_q;
    logic [c_cnt_w-1:0]     cnt_q;
    logic                   in_rdy_q;
    logic                   out_val_q;
    logic [4*DIGITS-1:0]    out_bcd_q;

    logic [4*DIGITS-1:0]    w_bcd_adj;
    logic [c_sr_w-1:0]      shift_d;

    // Add-3 correction on every digit >= 5 before the shift; 4-bit wrap is intended.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ?
                                         (bcd_q[4*k +: 4] + 4'd3) :
                                          bcd_q[4*k +: 4];
        end
    endgenerate

    assign shift_d = {w_bcd_adj, sh_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
            out_bcd_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_val && in_rdy_q) begin
                        sh_q     <= bus.in_bin;
                        bcd_q    <= '0;
                        cnt_q    <= c_cnt_init;
                        in_rdy_q <= 1'b0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, sh_q} <= shift_d;
                    cnt_q         <= cnt_q - c_cnt_one;
                    // Result register is loaded only on completion so it never shows partial sums.
                    if (cnt_q == c_cnt_one) begin
                        out_bcd_q <= shift_d[c_sr_w-1 -: 4*DIGITS];
                        out_val_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    out_val_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_val = out_val_q;
    assign bus.out_bcd = out_bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
// ============================================================================
// Module      : tb_binary_to_bcd_seq
// Description : Self-checking bench for binary_to_bcd_seq with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_binary_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [11:0] exp_q[$];

    binary_to_bcd_seq_if #(.IN_BITS(8), .DIGITS(3)) bus ();

    binary_to_bcd_seq #(.IN_BITS(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_rdy_wait", 32'(bus.in_rdy), 32'd1);
        bus.in_val = 1'b1;
        bus.in_bin = 8'(v);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(ref_bcd(v));
        bus.in_val = 1'b0;
        bus.in_bin = ~8'(v);
    endtask

    task automatic get_result(input int hold);
        logic [11:0] exp;
        logic [11:0] snap;
        logic        dig_bad;
        int          n;
        bus.out_rdy = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!bus.out_val && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_val) begin
            check("timeout", 32'(bus.out_val), 32'd1);
            return;
        end
        check("latency", 32'(cyc - acc_cyc), 32'd8);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check("bcd", 32'(bus.out_bcd), 32'(exp));
        dig_bad = (bus.out_bcd[3:0] > 4'd9) || (bus.out_bcd[7:4] > 4'd9) ||
                  (bus.out_bcd[11:8] > 4'd9);
        check("digit_le9", 32'(dig_bad), 32'd0);
        snap = bus.out_bcd;
        for (int i = 0; i < hold; i++) begin
            check("hold_val", 32'(bus.out_val), 32'd1);
            check("hold_bcd", 32'(bus.out_bcd), 32'(snap));
            check("hold_rdy", 32'(bus.in_rdy), 32'd0);
            @(negedge clk);
        end
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        check("post_val", 32'(bus.out_val), 32'd0);
        check("post_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("post_bcd", 32'(bus.out_bcd), 32'(snap));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_bin  = '0;
        bus.out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rst_out_val", 32'(bus.out_val), 32'd0);
        check("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
        rst_n = 1'b1;

        // Zero operand, then typical values.
        send(0);   get_result(0);
        send(255); get_result(0);
        send(100); get_result(1);
        send(9);   get_result(0);

        // Downstream stall for six cycles.
        send(123); get_result(6);

        // Reset in the middle of a conversion.
        send(200);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_val", 32'(bus.out_val), 32'd0);
        check("abort_out_bcd", 32'(bus.out_bcd), 32'd0);
        check("abort_in_rdy", 32'(bus.in_rdy), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(42); get_result(0);

        // in_val held high with a changing operand while busy.
        @(negedge clk);
        bus.in_val = 1'b1;
        bus.in_bin = 8'd17;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(ref_bcd(17));
        repeat (5) begin
            check("busy_in_rdy", 32'(bus.in_rdy), 32'd0);
            bus.in_bin = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_bin = 8'd99;
        get_result(2);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(ref_bcd(99));
        bus.in_val = 1'b0;
        get_result(0);

        // Every operand with a random downstream stall.
        for (int v = 0; v < 256; v++) begin
            send(v);
            get_result(int'($urandom_range(0, 2)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
